// File: rtl/writeback_ctrl.sv
// Writeback/commit stage: commits results to regfile/CSR, arbitrates interrupts
// against exceptions, and manages WFI sleep, the post-trap flush window and retire count.
`timescale 1ns/1ps
module writeback_ctrl #(
  parameter int XLEN        = 32,
  parameter int NUM_IRQ     = 3,
  parameter int CAUSE_W     = 4,
  parameter logic [NUM_IRQ*CAUSE_W-1:0] IRQ_CAUSES = {4'd11, 4'd7, 4'd3},
  parameter int FLUSH_DEPTH = 3,
  parameter int RETIRE_W    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     pc_in,
  input  logic [XLEN-1:0]     next_pc_in,
  input  logic [XLEN-1:0]     alu_data_in,
  input  logic [XLEN-1:0]     csr_data_in,
  input  logic [XLEN-1:0]     load_data_in,
  input  logic [1:0]          write_select_in,
  input  logic [4:0]          rd_address_in,
  input  logic [11:0]         csr_address_in,
  input  logic                csr_write_in,
  input  logic                mret_in,
  input  logic                wfi_in,
  input  logic                exception_in,
  input  logic [CAUSE_W-1:0]  ecause_in,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_enable,
  input  logic                global_ie,
  output logic                rd_we,
  output logic [4:0]          rd_address,
  output logic [XLEN-1:0]     rd_data,
  output logic                csr_write,
  output logic [11:0]         csr_address,
  output logic [XLEN-1:0]     csr_data,
  output logic                traped,
  output logic                mret,
  output logic                retired,
  output logic [XLEN-1:0]     ecp,
  output logic [CAUSE_W-1:0]  ecause,
  output logic                interupt,
  output logic                sleeping,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);

  typedef enum logic [1:0] {RUN, SLEEP, FLUSH} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;
  logic [XLEN-1:0]    r_wake_pc, w_wake_pc_nxt;

  logic [NUM_IRQ-1:0] w_pend;
  logic               w_take_irq;
  logic               w_accept;
  logic [CAUSE_W-1:0] w_irq_cause;
  logic [XLEN-1:0]    w_rd_data;

  logic               w_trap;
  logic               w_trap_irq;
  logic [CAUSE_W-1:0] w_trap_cause;
  logic [XLEN-1:0]    w_trap_pc;
  logic               w_commit;
  logic               w_retire_wfi;

  assign w_pend     = irq & irq_enable;
  assign w_take_irq = global_ie && (|w_pend);
  assign in_ready   = rst_n && (r_state != SLEEP);
  assign w_accept   = in_valid && in_ready;
  assign sleeping   = (r_state == SLEEP);

  // Ascending scan so the highest pending index is the one left standing.
  always_comb begin
    w_irq_cause = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (w_pend[i]) w_irq_cause = IRQ_CAUSES[i*CAUSE_W +: CAUSE_W];
  end

  always_comb begin
    unique case (write_select_in)
      2'b00:   w_rd_data = alu_data_in;
      2'b01:   w_rd_data = csr_data_in;
      2'b10:   w_rd_data = load_data_in;
      default: w_rd_data = next_pc_in;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wake_pc_nxt   = r_wake_pc;
    w_trap          = 1'b0;
    w_trap_irq      = 1'b0;
    w_trap_cause    = w_irq_cause;
    w_trap_pc       = pc_in;
    w_commit        = 1'b0;
    w_retire_wfi    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_accept) begin
          if (w_take_irq) begin
            w_trap     = 1'b1;
            w_trap_irq = 1'b1;
          end else if (exception_in) begin
            w_trap       = 1'b1;
            w_trap_cause = ecause_in;
          end else if (wfi_in) begin
            w_state_nxt   = SLEEP;
            w_wake_pc_nxt = next_pc_in;
          end else begin
            w_commit = 1'b1;
          end
        end
      end
      SLEEP: begin
        if (|w_pend) begin
          if (global_ie) begin
            w_trap     = 1'b1;
            w_trap_irq = 1'b1;
            w_trap_pc  = r_wake_pc;
          end else begin
            w_retire_wfi = 1'b1;
            w_state_nxt  = RUN;
          end
        end
      end
      FLUSH: begin
        if (w_accept) begin
          w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
          if (r_flush_cnt == CNT_W'(1)) w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
    if (w_trap) begin
      w_state_nxt     = FLUSH;
      w_flush_cnt_nxt = CNT_W'(FLUSH_DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      r_wake_pc   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wake_pc   <= w_wake_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_we        <= 1'b0;
      rd_address   <= '0;
      rd_data      <= '0;
      csr_write    <= 1'b0;
      csr_address  <= '0;
      csr_data     <= '0;
      traped       <= 1'b0;
      mret         <= 1'b0;
      retired      <= 1'b0;
      ecp          <= '0;
      ecause       <= '0;
      interupt     <= 1'b0;
      retire_count <= '0;
    end else begin
      rd_we     <= w_commit && (rd_address_in != 5'd0);
      csr_write <= w_commit && csr_write_in;
      mret      <= w_commit && mret_in;
      traped    <= w_trap;
      retired   <= w_commit || w_retire_wfi;
      if (w_commit || w_retire_wfi) retire_count <= retire_count + RETIRE_W'(1);
      if (w_commit) begin
        rd_address  <= rd_address_in;
        rd_data     <= w_rd_data;
        csr_address <= csr_address_in;
        csr_data    <= alu_data_in;
      end
      if (w_trap) begin
        ecp      <= w_trap_pc;
        ecause   <= w_trap_cause;
        interupt <= w_trap_irq;
      end
    end
  end

endmodule
